operand_serializer: RTL and testbench
=====================================

// Module: operand_serializer
// PURPOSE
//  Host-side front end of the systolic accelerator; feeds the top-level serial
//    operand inputs (data_in_x, data_in_y, load_en, init).
//  Accepts N paired X/Y operand words per frame over a valid/ready handshake
//    and shifts each word out MSB-first on two bit-serial lines.
//  After the last word it pulses init once, then holds off the next frame
//    until the core reports result readiness.
// PARAMETERS
//  D_W   8  operand word width (bits shifted per word)
//  N     2  words per operand per frame (systolic dimension)
//  WORD  8  host word width; must equal D_W (elaboration error otherwise)
// PORTS
//  clk        in   1    single clock, all logic on rising edge
//  rst        in   1    asynchronous, active-low reset
//  s_valid    in   1    host word pair valid
//  s_ready    out  1    serializer can accept a word pair this cycle
//  s_x        in   D_W  X operand word
//  s_y        in   D_W  Y operand word
//  abort      in   1    synchronous frame abort
//  core_rdy   in   1    result ready from core (top tx_ready)
//  ser_x      out  1    serial X bit   -> top data_in_x
//  ser_y      out  1    serial Y bit   -> top data_in_y
//  load_en    out  1    serial bit valid -> top load_en
//  init       out  1    frame-complete pulse -> top init
//  busy       out  1    frame in progress (state != IDLE or word_cnt != 0)
//  frame_cnt  out  8    frames sent, wraps 255->0
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; bit_cnt=0; word_cnt=0; frame_cnt=0.
//    All outputs are 0 except s_ready, which is 1.
//  Handshake: a word is accepted on an edge where s_valid & s_ready.
//    s_x/s_y are captured into shift regs sx/sy.
//  All outputs are registered; s_ready is decoded from registered state only.
//  State IDLE: s_ready=1, load_en=0, ser_x=ser_y=0.
//    On accept -> SHIFT, bit_cnt=0.
//  State SHIFT: load_en=1, ser_x=sx[D_W-1], ser_y=sy[D_W-1]; shift left each cycle.
//    Cycles 0..D_W-2: bit_cnt++.
//    Cycle D_W-1 (last bit), not last word (word_cnt != N-1): s_ready=1.
//      Accept -> reload, stay SHIFT, bit_cnt=0, word_cnt++ (no gap cycle).
//      No accept -> IDLE, word_cnt++.
//    Cycle D_W-1, last word: s_ready=0 -> INIT.
//  State INIT: exactly 1 cycle. init=1, load_en=0, word_cnt=0, frame_cnt++ -> WAIT.
//  State WAIT: s_ready=0, all serial outputs 0.
//    core_rdy sampled 1 -> IDLE. Level-sensitive; core_rdy high during INIT is ignored.
//  Latency: accept at edge k; first bit on ser_x/load_en valid from edge k+1.
//    The word occupies D_W consecutive load_en cycles.
//    init rises at edge k+1+N*D_W for a back-to-back frame (k = first accept).
//  abort=1 (any state): next edge -> IDLE, word_cnt=0, bit_cnt=0; init is not pulsed.
//    frame_cnt is unchanged. abort has priority over accept and core_rdy.
//  s_valid may drop between words; the frame resumes at the next accept.
//    No timeout.
//  s_x/s_y are don't-care when s_valid=0; no X propagates into sx/sy.
//  Reset asserted mid-frame: outputs clear immediately.
//    The partial frame is discarded; no init is issued.
// TESTING
//  T1 reset: rst=0 mid-SHIFT -> ser_x/load_en/init=0 and s_ready=1 same cycle.
//    frame_cnt=0.
//  T2 back-to-back frame (D_W=8,N=2): accept (A5,3C) then (0F,F0) continuously.
//    ser_x=1010_0101_0000_1111; ser_y=0011_1100_1111_0000.
//    load_en high 16 cycles; init one cycle later; frame_cnt=1.
//  T3 gapped input: s_valid low 5 cycles between words -> load_en low for exactly
//    those idle cycles; the bitstream is identical to T2.
//  T4 core hold-off: core_rdy=0 for 20 cycles after init -> s_ready stays 0.
//    core_rdy=1 -> s_ready=1 next cycle.
//  T5 abort during word 1 bit 3 -> IDLE next edge, no init, frame_cnt unchanged.
//    The next full frame is sent correctly.
//  T6 wrap: 256 frames with core_rdy tied 1 -> frame_cnt returns to 0.
//    Random valid stalls -> scoreboard matches every bit.

Source files
------------

// File: rtl/operand_serializer.sv
// Host-side operand front end: takes N X/Y word pairs per frame, shifts them out
// MSB-first on two serial lines, pulses init, then waits for the core's result.
module operand_serializer #(
  parameter int D_W  = 8,
  parameter int N    = 2,
  parameter int WORD = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           s_valid,
  output logic           s_ready,
  input  logic [D_W-1:0] s_x,
  input  logic [D_W-1:0] s_y,
  input  logic           abort,
  input  logic           core_rdy,
  output logic           ser_x,
  output logic           ser_y,
  output logic           load_en,
  output logic           init,
  output logic           busy,
  output logic [7:0]     frame_cnt
);

  localparam int BW = (D_W > 1) ? $clog2(D_W) : 1;
  localparam int WW = (N > 1) ? $clog2(N) : 1;

  generate
    if (WORD != D_W) begin : g_word_chk
      $error("operand_serializer: WORD must equal D_W");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, SHIFT, INIT, WAIT} state_t;

  state_t          r_state, w_next_state;
  logic [BW-1:0]   r_bit_cnt;
  logic [WW-1:0]   r_word_cnt;
  logic [D_W-1:0]  r_sx, r_sy;
  logic [7:0]      r_frame_cnt;
  logic            w_accept, w_last_bit, w_last_word;

  assign w_last_bit  = (r_bit_cnt == BW'(D_W - 1));
  assign w_last_word = (r_word_cnt == WW'(N - 1));
  assign w_accept    = s_valid & s_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next_state;
  end

  // abort overrides every transition, including accepts and core release
  always_comb begin
    w_next_state = r_state;
    if (abort) begin
      w_next_state = IDLE;
    end else begin
      case (r_state)
        IDLE:  if (w_accept) w_next_state = SHIFT;
        SHIFT: if (w_last_bit) begin
                 if (w_last_word)    w_next_state = INIT;
                 else if (!w_accept) w_next_state = IDLE;
               end
        INIT:  w_next_state = WAIT;
        WAIT:  if (core_rdy) w_next_state = IDLE;
        default: w_next_state = IDLE;
      endcase
    end
  end

  // every output is a decode of registered state, never of live inputs
  always_comb begin
    s_ready   = (r_state == IDLE) |
                ((r_state == SHIFT) & w_last_bit & ~w_last_word);
    load_en   = (r_state == SHIFT);
    ser_x     = (r_state == SHIFT) & r_sx[D_W-1];
    ser_y     = (r_state == SHIFT) & r_sy[D_W-1];
    init      = (r_state == INIT);
    busy      = (r_state != IDLE) | (r_word_cnt != '0);
    frame_cnt = r_frame_cnt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bit_cnt   <= '0;
      r_word_cnt  <= '0;
      r_sx        <= '0;
      r_sy        <= '0;
      r_frame_cnt <= '0;
    end else if (abort) begin
      r_bit_cnt  <= '0;
      r_word_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
                r_sx      <= s_x;
                r_sy      <= s_y;
                r_bit_cnt <= '0;
              end
        SHIFT: begin
          if (!w_last_bit) begin
            r_bit_cnt <= r_bit_cnt + BW'(1);
            r_sx      <= {r_sx[D_W-2:0], 1'b0};
            r_sy      <= {r_sy[D_W-2:0], 1'b0};
          end else begin
            r_bit_cnt <= '0;
            if (!w_last_word) begin
              r_word_cnt <= r_word_cnt + WW'(1);
              // reload on the last bit keeps back-to-back words gapless
              if (w_accept) begin
                r_sx <= s_x;
                r_sy <= s_y;
              end
            end
          end
        end
        INIT: begin
          r_word_cnt  <= '0;
          r_frame_cnt <= r_frame_cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_operand_serializer.sv
// Scoreboard bench for operand_serializer: expected serial bit pairs are queued
// on each accepted word and popped whenever load_en is seen.
module tb_operand_serializer;

  localparam int D_W = 8;
  localparam int N   = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       s_valid, s_ready, abort, core_rdy;
  logic [7:0] s_x, s_y;
  logic       ser_x, ser_y, load_en, init, busy;
  logic [7:0] frame_cnt;

  operand_serializer #(.D_W(D_W), .N(N), .WORD(8)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
    .s_x(s_x), .s_y(s_y), .abort(abort), .core_rdy(core_rdy),
    .ser_x(ser_x), .ser_y(ser_y), .load_en(load_en), .init(init),
    .busy(busy), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int          cyc_n = 0;
  int          load_cnt = 0;
  int          init_cnt = 0;
  int          last_init = -1;
  logic [15:0] cap_x, cap_y;
  logic [1:0]  sbq[$];

  // One clock: drive inputs after a negedge, score serial output at the next negedge.
  task automatic cyc(input logic v, input logic [7:0] x, input logic [7:0] y,
                     input logic ab, output bit acc);
    logic [1:0] exp_b;
    s_valid = v;
    s_x     = v ? x : 8'($urandom);
    s_y     = v ? y : 8'($urandom);
    abort   = ab;
    acc     = v && s_ready && !ab;
    if (acc) for (int b = 7; b >= 0; b--) sbq.push_back({x[b], y[b]});
    @(negedge clk);
    cyc_n++;
    if (ab) sbq.delete();
    checks++;
    if (load_en) begin
      load_cnt++;
      cap_x = {cap_x[14:0], ser_x};
      cap_y = {cap_y[14:0], ser_y};
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_bit cyc=%0d got x=%b y=%b, no bit expected", cyc_n, ser_x, ser_y);
      end else begin
        exp_b = sbq.pop_front();
        if ({ser_x, ser_y} !== exp_b) begin
          errors++;
          $display("FAIL sb_bit cyc=%0d got xy=%b%b want %b", cyc_n, ser_x, ser_y, exp_b);
        end
      end
    end else if ({ser_x, ser_y} !== 2'b00) begin
      errors++;
      $display("FAIL serial_idle cyc=%0d got xy=%b%b want 00", cyc_n, ser_x, ser_y);
    end
    if (init) begin
      init_cnt++;
      last_init = cyc_n;
    end
  endtask

  task automatic run_frame(input logic [7:0] x0, input logic [7:0] y0,
                           input logic [7:0] x1, input logic [7:0] y1,
                           input int gap, input bit rnd,
                           output int t_first, output int t_init, output int loads);
    int wi, budget, hold, l0, i0;
    bit acc, v;
    logic [7:0] wx, wy;
    wi = 0; budget = 0; hold = 0; l0 = load_cnt; i0 = init_cnt; t_first = -1;
    cap_x = '0; cap_y = '0;
    while (wi < N && budget < 500) begin
      wx = (wi == 0) ? x0 : x1;
      wy = (wi == 0) ? y0 : y1;
      v  = 1'b1;
      if (hold > 0) begin v = 1'b0; hold--; end
      else if (rnd && $urandom_range(0, 3) == 0) v = 1'b0;
      cyc(v, wx, wy, 1'b0, acc);
      if (acc) begin
        if (wi == 0) t_first = cyc_n;
        wi++;
        hold = (gap > 0) ? D_W - 1 + gap : 0;
      end
      budget++;
    end
    while (init_cnt == i0 && budget < 500) begin
      cyc(1'b0, 8'h00, 8'h00, 1'b0, acc);
      budget++;
    end
    checks++;
    if (init_cnt == i0) begin
      errors++;
      $display("FAIL frame_timeout init not seen after %0d cycles", budget);
    end
    t_init = last_init;
    loads  = load_cnt - l0;
  endtask

  task automatic test_reset;
    bit acc;
    rst = 1'b0; s_valid = 1'b0; s_x = '0; s_y = '0; abort = 1'b0; core_rdy = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({s_ready, ser_x, ser_y, load_en, init, busy} !== 6'b100000 || frame_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_state got rdy/x/y/ld/init/busy=%b fc=%0d want 100000 fc=0",
               {s_ready, ser_x, ser_y, load_en, init, busy}, frame_cnt);
    end
    rst = 1'b1;
    cyc(1'b1, 8'hA5, 8'h3C, 1'b0, acc);
    cyc(1'b0, 8'h00, 8'h00, 1'b0, acc);
    cyc(1'b0, 8'h00, 8'h00, 1'b0, acc);
    checks++;
    if (load_en !== 1'b1 || ser_x !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre_shift got ld=%b x=%b want ld=1 x=1", load_en, ser_x);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({s_ready, ser_x, ser_y, load_en, init, busy} !== 6'b100000 || frame_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_mid_shift got rdy/x/y/ld/init/busy=%b fc=%0d want 100000 fc=0",
               {s_ready, ser_x, ser_y, load_en, init, busy}, frame_cnt);
    end
    sbq.delete();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_back_to_back;
    int tf, ti, ld;
    bit acc;
    core_rdy = 1'b0;
    run_frame(8'hA5, 8'h3C, 8'h0F, 8'hF0, 0, 1'b0, tf, ti, ld);
    checks++;
    if (cap_x !== 16'hA50F || cap_y !== 16'h3CF0) begin
      errors++;
      $display("FAIL b2b_stream got x=%h y=%h want A50F 3CF0", cap_x, cap_y);
    end
    checks++;
    if (ld != 16 || ti - tf != N * D_W) begin
      errors++;
      $display("FAIL b2b_timing got loads=%0d init_delay=%0d want 16 16", ld, ti - tf);
    end
    cyc(1'b0, 8'h00, 8'h00, 1'b0, acc);
    checks++;
    if (frame_cnt !== 8'd1 || init !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_after got fc=%0d init=%b busy=%b want 1 0 1", frame_cnt, init, busy);
    end
    core_rdy = 1'b1;
    cyc(1'b0, 8'h00, 8'h00, 1'b0, acc);
    core_rdy = 1'b0;
  endtask

  task automatic test_holdoff;
    int tf, ti, ld;
    bit acc;
    core_rdy = 1'b0;
    run_frame(8'h5A, 8'hC3, 8'h81, 8'h7E, 0, 1'b0, tf, ti, ld);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 8'h00, 8'h00, 1'b0, acc);
      checks++;
      if (s_ready !== 1'b0) begin
        errors++;
        $display("FAIL holdoff_ready cyc=%0d got %b want 0", i, s_ready);
      end
    end
    checks++;
    if (frame_cnt !== 8'd2) begin
      errors++;
      $display("FAIL holdoff_fc got %0d want 2", frame_cnt);
    end
    core_rdy = 1'b1;
    cyc(1'b0, 8'h00, 8'h00, 1'b0, acc);
    core_rdy = 1'b0;
    checks++;
    if (s_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL holdoff_release got rdy=%b busy=%b want 1 0", s_ready, busy);
    end
  endtask

  task automatic test_gapped;
    int tf, ti, ld;
    bit acc;
    run_frame(8'hA5, 8'h3C, 8'h0F, 8'hF0, 5, 1'b0, tf, ti, ld);
    checks++;
    if (cap_x !== 16'hA50F || cap_y !== 16'h3CF0) begin
      errors++;
      $display("FAIL gap_stream got x=%h y=%h want A50F 3CF0", cap_x, cap_y);
    end
    checks++;
    if (ld != 16 || ti - tf != N * D_W + 5) begin
      errors++;
      $display("FAIL gap_timing got loads=%0d init_delay=%0d want 16 21", ld, ti - tf);
    end
    core_rdy = 1'b1;
    cyc(1'b0, 8'h00, 8'h00, 1'b0, acc);
    cyc(1'b0, 8'h00, 8'h00, 1'b0, acc);
    core_rdy = 1'b0;
    checks++;
    if (frame_cnt !== 8'd3 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL gap_after got fc=%0d rdy=%b want 3 1", frame_cnt, s_ready);
    end
  endtask

  task automatic test_abort;
    int tf, ti, ld, i0, budget;
    bit acc;
    i0 = init_cnt;
    cyc(1'b1, 8'hA5, 8'h3C, 1'b0, acc);
    acc = 1'b0; budget = 0;
    while (!acc && budget < 50) begin
      cyc(1'b1, 8'h0F, 8'hF0, 1'b0, acc);
      budget++;
    end
    repeat (3) cyc(1'b0, 8'h00, 8'h00, 1'b0, acc);
    cyc(1'b0, 8'h00, 8'h00, 1'b1, acc);
    checks++;
    if (load_en !== 1'b0 || s_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle got ld=%b rdy=%b busy=%b want 0 1 0", load_en, s_ready, busy);
    end
    repeat (4) cyc(1'b0, 8'h00, 8'h00, 1'b0, acc);
    checks++;
    if (init_cnt != i0 || frame_cnt !== 8'd3) begin
      errors++;
      $display("FAIL abort_no_init got inits=%0d fc=%0d want %0d 3", init_cnt - i0, frame_cnt, 0);
    end
    run_frame(8'h3C, 8'hA5, 8'hF0, 8'h0F, 0, 1'b0, tf, ti, ld);
    checks++;
    if (cap_x !== 16'h3CF0 || cap_y !== 16'hA50F || ti - tf != N * D_W) begin
      errors++;
      $display("FAIL abort_next got x=%h y=%h delay=%0d want 3CF0 A50F 16", cap_x, cap_y, ti - tf);
    end
    cyc(1'b0, 8'h00, 8'h00, 1'b0, acc);
    checks++;
    if (frame_cnt !== 8'd4) begin
      errors++;
      $display("FAIL abort_fc got %0d want 4", frame_cnt);
    end
  endtask

  task automatic test_wrap;
    int tf, ti, ld, fc0;
    bit acc;
    logic [7:0] x0, y0, x1, y1;
    core_rdy = 1'b1;
    fc0 = 4;
    for (int f = 0; f < 256; f++) begin
      x0 = 8'($urandom); y0 = 8'($urandom); x1 = 8'($urandom); y1 = 8'($urandom);
      run_frame(x0, y0, x1, y1, 0, 1'b1, tf, ti, ld);
      checks++;
      if (cap_x !== {x0, x1} || cap_y !== {y0, y1} || ld != 16) begin
        errors++;
        $display("FAIL wrap_stream f=%0d got x=%h y=%h loads=%0d want %h %h 16",
                 f, cap_x, cap_y, ld, {x0, x1}, {y0, y1});
      end
      cyc(1'b0, 8'h00, 8'h00, 1'b0, acc);
      checks++;
      if (frame_cnt !== 8'(fc0 + f + 1)) begin
        errors++;
        $display("FAIL wrap_fc f=%0d got %0d want %0d", f, frame_cnt, 8'(fc0 + f + 1));
      end
    end
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL wrap_leftover got %0d queued bits want 0", sbq.size());
    end
    core_rdy = 1'b0;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_holdoff();
    test_gapped();
    test_abort();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
